// File: rtl/mult_div_unit_if.sv
// Shared word type and operation encoding, plus the request/result bundle
// between the execute stage and the iterative multiply/divide unit.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;
endpackage

interface mult_div_unit_if;
  import cpu_types_pkg::*;

  logic   start;
  md_op_e op;
  word_t  port_a;
  word_t  port_b;
  logic   flush;
  logic   busy;
  logic   done;
  logic   div_by_zero;
  word_t  hi;
  word_t  lo;

  modport master (
    output start, op, port_a, port_b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, port_a, port_b, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: magnitudes in, 32 shift-add or
// restoring steps on a 64-bit register, sign fix-up and HI/LO write-back.
module mult_div_unit
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;        // multiply: {acc, multiplier}; divide: {rem, quo}
  word_t       opb_q;        // multiplicand or divisor magnitude
  word_t       raw_a_q;
  logic        is_div_q;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic        dbz_pend_q;
  word_t       hi_q, lo_q;
  logic        done_q;
  logic        dbz_q;

  logic        accept;
  logic        signed_op;
  logic        zero_div;
  word_t       mag_a, mag_b;

  assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush;
  assign signed_op = ~bus.op[0];
  assign zero_div  = bus.op[1] && (bus.port_b == '0);
  // 0x80000000 negates to itself, which is its correct unsigned magnitude.
  assign mag_a     = (signed_op && bus.port_a[31]) ? -bus.port_a : bus.port_a;
  assign mag_b     = (signed_op && bus.port_b[31]) ? -bus.port_b : bus.port_b;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = zero_div ? S_SIGN : S_CALC;
      S_CALC: begin
        if (bus.flush)          state_d = S_IDLE;
        else if (cnt_q == 5'd31) state_d = S_SIGN;
      end
      S_SIGN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: all driven from registers only
  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = done_q;
    bus.div_by_zero = dbz_q;
    bus.hi          = hi_q;
    bus.lo          = lo_q;
  end

  // One iteration step for each operation class
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] step_val;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = div_sh - {1'b0, opb_q};
    if (is_div_q) begin
      // Partial remainder stays below the divisor, so a borrow means "restore".
      step_val = div_diff[32] ? {div_sh[31:0],   acc_q[30:0], 1'b0}
                              : {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      step_val = {mul_sum, acc_q[31:1]};
    end
  end

  // Sign correction and write-back selection
  logic [63:0] prod;
  word_t       quo, rem;
  word_t       wb_hi, wb_lo;

  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = neg_res_q ? -acc_q[31:0]  : acc_q[31:0];
    rem  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
    if (dbz_pend_q) begin
      wb_hi = raw_a_q;
      wb_lo = 32'hFFFF_FFFF;
    end else if (is_div_q) begin
      wb_hi = rem;
      wb_lo = quo;
    end else begin
      wb_hi = prod[63:32];
      wb_lo = prod[31:0];
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      raw_a_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      cnt_q      <= '0;
      acc_q      <= {32'd0, mag_a};
      opb_q      <= mag_b;
      raw_a_q    <= bus.port_a;
      is_div_q   <= bus.op[1];
      neg_res_q  <= signed_op && (bus.port_a[31] ^ bus.port_b[31]);
      neg_rem_q  <= (bus.op == OP_DIV) && bus.port_a[31];
      dbz_pend_q <= zero_div;
    end else if (state_q == S_CALC) begin
      acc_q <= step_val;
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // Architectural HI/LO, done pulse and divide-by-zero flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_SIGN) && !bus.flush;
      if ((state_q == S_SIGN) && !bus.flush) begin
        hi_q  <= wb_hi;
        lo_q  <= wb_lo;
        dbz_q <= dbz_pend_q;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned results,
// divide by zero, back-to-back, ignored start, flush and async reset.
module tb_mult_div_unit;
  import cpu_types_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if mdu_if ();

  mult_div_unit u_dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (mdu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge (E0), then scrambles the operand inputs.
  task automatic issue(input md_op_e op, input word_t a, input word_t b);
    mdu_if.start  = 1'b1;
    mdu_if.op     = op;
    mdu_if.port_a = a;
    mdu_if.port_b = b;
    tick();
    mdu_if.start  = 1'b0;
    mdu_if.op     = OP_DIVU;
    mdu_if.port_a = 32'hDEAD_BEEF;
    mdu_if.port_b = 32'h0;
  endtask

  // Waits for done; poke_at > 0 pulses a stray start after that many edges.
  task automatic wait_done(input string tag, input int poke_at, output int lat);
    int gap = 0;
    lat = 0;
    check({tag, "_busy_e0"}, 64'(mdu_if.busy), 64'd1);
    for (int n = 1; n <= 40; n++) begin
      if (n == poke_at + 1 && poke_at > 0) begin
        mdu_if.start  = 1'b1;
        mdu_if.op     = OP_MULT;
        mdu_if.port_a = 32'h0000_0100;
        mdu_if.port_b = 32'h0000_0100;
      end
      tick();
      mdu_if.start = 1'b0;
      if (mdu_if.done) begin
        lat = n;
        break;
      end
      if (!mdu_if.busy) gap++;
    end
    check({tag, "_busy_gap"}, 64'(gap), 64'd0);
  endtask

  task automatic run(input string tag, input md_op_e op, input word_t a, input word_t b,
                     input word_t exp_hi, input word_t exp_lo, input logic exp_dbz,
                     input int exp_lat, input int poke_at);
    int lat;
    issue(op, a, b);
    wait_done(tag, poke_at, lat);
    check({tag, "_lat"},  64'(lat),                exp_lat);
    check({tag, "_hi"},   64'(mdu_if.hi),          64'(exp_hi));
    check({tag, "_lo"},   64'(mdu_if.lo),          64'(exp_lo));
    check({tag, "_dbz"},  64'(mdu_if.div_by_zero), 64'(exp_dbz));
    check({tag, "_busy"}, 64'(mdu_if.busy),        64'd0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (mdu_if.done) cnt++;
    end
  endtask

  initial begin
    int dones;
    rst_n         = 1'b0;
    mdu_if.start  = 1'b0;
    mdu_if.flush  = 1'b0;
    mdu_if.op     = OP_MULT;
    mdu_if.port_a = '0;
    mdu_if.port_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    check("rst_hi",   64'(mdu_if.hi),          64'd0);
    check("rst_lo",   64'(mdu_if.lo),          64'd0);
    check("rst_busy", 64'(mdu_if.busy),        64'd0);
    check("rst_done", 64'(mdu_if.done),        64'd0);
    check("rst_dbz",  64'(mdu_if.div_by_zero), 64'd0);

    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 0);
    tick();
    check("multu_max_done_fall", 64'(mdu_if.done), 64'd0);

    run("mult_neg",  OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 0);
    run("mult_min",  OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 0);
    tick();

    // Second divide is issued in the done cycle of the first.
    run("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0);
    run("divu_b2b",  OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 33, 0);
    tick();

    run("divu_zero", OP_DIVU, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1, 0);
    tick();

    // Stray start after E5 must be neither accepted nor queued.
    run("multu_ign", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, 5);
    count_dones(40, dones);
    check("multu_ign_no_queue", 64'(dones), 64'd0);
    check("multu_ign_busy",     64'(mdu_if.busy), 64'd0);

    run("div_ovf",   OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 0);
    tick();

    // Flush sampled at E11 of a MULT.
    issue(OP_MULT, 32'd5, 32'd7);
    repeat (10) tick();
    mdu_if.flush = 1'b1;
    tick();
    mdu_if.flush = 1'b0;
    check("flush_busy", 64'(mdu_if.busy), 64'd0);
    check("flush_done", 64'(mdu_if.done), 64'd0);
    count_dones(40, dones);
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_hi", 64'(mdu_if.hi), 64'h0);
    check("flush_lo", 64'(mdu_if.lo), 64'h8000_0000);

    // Flush in IDLE drops a simultaneous start.
    mdu_if.start  = 1'b1;
    mdu_if.flush  = 1'b1;
    mdu_if.op     = OP_MULTU;
    mdu_if.port_a = 32'd9;
    mdu_if.port_b = 32'd9;
    tick();
    mdu_if.start = 1'b0;
    mdu_if.flush = 1'b0;
    check("flush_idle_busy", 64'(mdu_if.busy), 64'd0);
    count_dones(40, dones);
    check("flush_idle_no_done", 64'(dones), 64'd0);

    // Asynchronous reset between edges in the middle of CALC.
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi",   64'(mdu_if.hi),          64'd0);
    check("arst_lo",   64'(mdu_if.lo),          64'd0);
    check("arst_busy", 64'(mdu_if.busy),        64'd0);
    check("arst_done", 64'(mdu_if.done),        64'd0);
    check("arst_dbz",  64'(mdu_if.div_by_zero), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle", 64'(mdu_if.busy), 64'd0);

    run("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
